// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the boot loader.
// The master modport is the host/sender side; the slave modport is the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  Start;
    logic [7:0]            RxData;
    logic                  RxValid;
    logic                  RxReady;
    logic [31:0]           MemAddress;
    logic [31:0]           MemWriteData;
    logic                  MemWrite;
    logic                  ProcReset_L;
    logic [31:0]           StartPC;
    logic                  Done;
    logic                  Error;
    logic [ADDR_WIDTH:0]   WordCount;

    modport master (
        output Start, RxData, RxValid,
        input  RxReady, MemAddress, MemWriteData, MemWrite, ProcReset_L, StartPC,
        input  Done, Error, WordCount
    );

    modport slave (
        input  Start, RxData, RxValid,
        output RxReady, MemAddress, MemWriteData, MemWrite, ProcReset_L, StartPC,
        output Done, Error, WordCount
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: receives a framed byte stream, writes big-endian words to instruction
// memory, verifies the trailing checksum and releases the processor only after a good frame.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input logic          CLK,
    input logic          Reset_L,
    imem_loader_if.slave bus
);
    localparam int unsigned CntW     = ADDR_WIDTH + 1;
    localparam logic [16:0] MaxWords = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        StIdle, StHdrHi, StHdrLo, StPayload, StWrite, StCheck, StDone, StError
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [CntW-1:0]   wc_q, wc_d;
    logic              rx_ready_q, rx_ready_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              proc_reset_l_q, proc_reset_l_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic [15:0]       n_full;
    logic [CntW-1:0]   wc_inc;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q        <= StIdle;
            n_q            <= '0;
            lane_q         <= '0;
            word_q         <= '0;
            csum_q         <= '0;
            wc_q           <= '0;
            rx_ready_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= BASE_ADDR;
            mem_wdata_q    <= '0;
            proc_reset_l_q <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            lane_q         <= lane_d;
            word_q         <= word_d;
            csum_q         <= csum_d;
            wc_q           <= wc_d;
            rx_ready_q     <= rx_ready_d;
            mem_write_q    <= mem_write_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            proc_reset_l_q <= proc_reset_l_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        lane_d      = lane_q;
        word_d      = word_q;
        csum_d      = csum_q;
        wc_d        = wc_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        accept = bus.RxValid & rx_ready_q;
        n_full = {n_q[15:8], bus.RxData};
        wc_inc = wc_q + 1'b1;

        case (state_q)
            StIdle, StDone, StError: begin
                if (bus.Start) begin
                    state_d = StHdrHi;
                    wc_d    = '0;
                    csum_d  = '0;
                    lane_d  = '0;
                end
            end
            StHdrHi: begin
                if (accept) begin
                    n_d[15:8] = bus.RxData;
                    csum_d    = csum_q + bus.RxData;
                    state_d   = StHdrLo;
                end
            end
            StHdrLo: begin
                if (accept) begin
                    n_d[7:0] = bus.RxData;
                    csum_d   = csum_q + bus.RxData;
                    if ({1'b0, n_full} > MaxWords) begin
                        state_d = StError;
                    end else if (n_full == 16'd0) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                if (accept) begin
                    word_d = {word_q[23:0], bus.RxData};
                    csum_d = csum_q + bus.RxData;
                    lane_d = lane_q + 2'd1;
                    // Fourth lane: latch the write so the strobe appears as a registered pulse.
                    if (lane_q == 2'd3) begin
                        state_d     = StWrite;
                        mem_write_d = 1'b1;
                        mem_addr_d  = BASE_ADDR + 32'({wc_q, 2'b00});
                        mem_wdata_d = word_d;
                    end
                end
            end
            StWrite: begin
                wc_d    = wc_inc;
                state_d = (17'(wc_inc) == {1'b0, n_q}) ? StCheck : StPayload;
            end
            StCheck: begin
                if (accept) begin
                    state_d = (bus.RxData == csum_q) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase

        rx_ready_d     = (state_d == StHdrHi) || (state_d == StHdrLo) ||
                         (state_d == StPayload) || (state_d == StCheck);
        done_d         = (state_d == StDone);
        error_d        = (state_d == StError);
        proc_reset_l_d = (state_d == StDone);
    end

    assign bus.RxReady      = rx_ready_q;
    assign bus.MemWrite     = mem_write_q;
    assign bus.MemAddress   = mem_addr_q;
    assign bus.MemWriteData = mem_wdata_q;
    assign bus.ProcReset_L  = proc_reset_l_q;
    assign bus.Done         = done_q;
    assign bus.Error        = error_q;
    assign bus.WordCount    = wc_q;
    assign bus.StartPC      = BASE_ADDR;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a frame-level model queues expected writes and end status,
// and an independent monitor compares them as the DUT presents them.
module tb_imem_loader;
    localparam int unsigned AW   = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic CLK = 1'b0;
    logic Reset_L = 1'b1;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { bit done; bit err; int wc; } st_t;

    wr_t         exp_wr[$];
    st_t         exp_st[$];
    logic [7:0]  frm[$];
    logic [31:0] wds[$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every write strobe and every Done/Error rising edge against the queues.
    bit fin_prev = 1'b0;
    bit mw_prev  = 1'b0;
    always @(negedge CLK) begin
        if (Reset_L) begin
            if (bus.MemWrite) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected MemWrite", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("MemAddress", bus.MemAddress, w.addr);
                    check("MemWriteData", bus.MemWriteData, w.data);
                    check("RxReady during write", {31'd0, bus.RxReady}, 32'd0);
                    check("MemWrite single cycle", {31'd0, mw_prev}, 32'd0);
                end
            end
            if ((bus.Done | bus.Error) && !fin_prev) begin
                if (exp_st.size() == 0) begin
                    check("unexpected end status", 32'd1, 32'd0);
                end else begin
                    st_t s;
                    s = exp_st.pop_front();
                    check("Done", {31'd0, bus.Done}, {31'd0, s.done});
                    check("Error", {31'd0, bus.Error}, {31'd0, s.err});
                    check("ProcReset_L", {31'd0, bus.ProcReset_L}, {31'd0, s.done});
                    check("WordCount", 32'(bus.WordCount), 32'(s.wc));
                    check("RxReady at end", {31'd0, bus.RxReady}, 32'd0);
                end
            end
            fin_prev = bus.Done | bus.Error;
            mw_prev  = bus.MemWrite;
        end
    end

    // Reference model: parse the frame bytes by the framing rules.
    task automatic model_frame();
        int n, sum;
        n = int'(frm[0]) * 256 + int'(frm[1]);
        if (n > (1 << AW)) begin
            exp_st.push_back('{done: 1'b0, err: 1'b1, wc: 0});
            return;
        end
        sum = int'(frm[0]) + int'(frm[1]);
        for (int w = 0; w < n; w++) begin
            wr_t e;
            e.addr = BASE + 32'(4 * w);
            e.data = {frm[2 + 4*w], frm[3 + 4*w], frm[4 + 4*w], frm[5 + 4*w]};
            for (int k = 0; k < 4; k++) sum += int'(frm[2 + 4*w + k]);
            exp_wr.push_back(e);
        end
        if (int'(frm[2 + 4*n]) == (sum % 256))
            exp_st.push_back('{done: 1'b1, err: 1'b0, wc: n});
        else
            exp_st.push_back('{done: 1'b0, err: 1'b1, wc: n});
    endtask

    task automatic build_from_words(input bit bad);
        int sum, n;
        n = wds.size();
        frm.delete();
        frm.push_back(8'(n >> 8));
        frm.push_back(8'(n));
        foreach (wds[i]) begin
            frm.push_back(wds[i][31:24]);
            frm.push_back(wds[i][23:16]);
            frm.push_back(wds[i][15:8]);
            frm.push_back(wds[i][7:0]);
        end
        sum = 0;
        foreach (frm[i]) sum += int'(frm[i]);
        frm.push_back(8'(sum + (bad ? 1 : 0)));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bp);
        bit ok;
        if (bp) begin
            repeat ($urandom_range(0, 2)) begin
                bus.RxValid = 1'b0;
                bus.RxData  = 8'($urandom);
                @(posedge CLK); #1;
            end
        end
        bus.RxData  = b;
        bus.RxValid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge CLK);
            if (bus.RxReady) begin
                @(posedge CLK); #1;
                ok = 1'b1;
            end
        end
        bus.RxValid = 1'b0;
        if (!ok) check("byte accept timeout", 32'd0, 32'd1);
    endtask

    task automatic do_start();
        // A held byte before Start must not be consumed.
        bus.RxData  = 8'hA5;
        bus.RxValid = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        bus.RxValid = 1'b0;
        bus.Start   = 1'b1;
        @(posedge CLK); #1;
        bus.Start   = 1'b0;
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge CLK);
            if (bus.Done | bus.Error) seen = 1'b1;
        end
        if (!seen) check("end-of-frame timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
    endtask

    task automatic run_frame(input bit bp, input bit mid_start);
        int n;
        model_frame();
        do_start();
        n = int'(frm[0]) * 256 + int'(frm[1]);
        foreach (frm[i]) begin
            if (mid_start && i == 3) bus.Start = 1'b1;
            send_byte(frm[i], bp);
            bus.Start = 1'b0;
        end
        if (n > (1 << AW)) begin
            check("Error after oversize header", {31'd0, bus.Error}, 32'd1);
            check("RxReady after oversize header", {31'd0, bus.RxReady}, 32'd0);
        end
        wait_end();
    endtask

    task automatic check_reset_values();
        check("rst RxReady", {31'd0, bus.RxReady}, 32'd0);
        check("rst MemWrite", {31'd0, bus.MemWrite}, 32'd0);
        check("rst MemAddress", bus.MemAddress, BASE);
        check("rst MemWriteData", bus.MemWriteData, 32'd0);
        check("rst ProcReset_L", {31'd0, bus.ProcReset_L}, 32'd0);
        check("rst Done", {31'd0, bus.Done}, 32'd0);
        check("rst Error", {31'd0, bus.Error}, 32'd0);
        check("rst WordCount", 32'(bus.WordCount), 32'd0);
        check("StartPC", bus.StartPC, BASE);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Start   = 1'b0;
        bus.RxData  = 8'h00;
        bus.RxValid = 1'b0;
        #3 Reset_L = 1'b0;
        #1 check_reset_values();
        repeat (2) @(posedge CLK);
        @(negedge CLK) Reset_L = 1'b1;
        @(posedge CLK); #1;

        // Basic load
        frm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15};
        run_frame(1'b0, 1'b0);

        // Back-pressure, two words
        wds = '{32'hDEADBEEF, 32'h00000004};
        build_from_words(1'b0);
        run_frame(1'b1, 1'b0);

        // Bad checksum
        frm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h16};
        run_frame(1'b0, 1'b0);

        // Oversize header (N = 257)
        frm = '{8'h01, 8'h01};
        run_frame(1'b0, 1'b0);

        // Empty frame
        frm = '{8'h00, 8'h00, 8'h00};
        run_frame(1'b0, 1'b0);

        // Reset mid-frame after the 2nd payload byte, then a clean reload
        frm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15};
        do_start();
        for (int i = 0; i < 4; i++) send_byte(frm[i], 1'b0);
        Reset_L = 1'b0;
        #1 check_reset_values();
        repeat (3) @(posedge CLK);
        #1 check_reset_values();
        @(negedge CLK) Reset_L = 1'b1;
        @(posedge CLK); #1;
        run_frame(1'b0, 1'b0);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                int n;
                n = int'($urandom_range(257, 65535));
                frm = '{8'(n >> 8), 8'(n)};
                run_frame(1'b1, 1'b0);
            end else begin
                int n;
                n = int'($urandom_range(0, 6));
                wds.delete();
                for (int w = 0; w < n; w++) wds.push_back($urandom);
                build_from_words($urandom_range(0, 3) == 0);
                run_frame($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            end
        end

        repeat (5) @(posedge CLK);
        #1;
        check("pending writes", 32'(exp_wr.size()), 32'd0);
        check("pending status", 32'(exp_st.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
